// File: rtl/lia_iq_decimator.sv
// Dual-channel I/Q integrate-and-dump decimator: averages blocks of 2^k valid mixer
// products per channel and emits one registered I/Q pair per block.
module lia_iq_decimator #(
  parameter int IN_WIDTH = 24,
  parameter int MAX_LOG2 = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic                       clear,
  input  logic [3:0]                 decim_log2,
  input  logic signed [IN_WIDTH-1:0] in_i,
  input  logic signed [IN_WIDTH-1:0] in_q,
  input  logic                       in_valid,
  output logic signed [IN_WIDTH-1:0] out_i,
  output logic signed [IN_WIDTH-1:0] out_q,
  output logic                       out_valid,
  output logic                       busy
);

  localparam int ACC_WIDTH = IN_WIDTH + MAX_LOG2;

  logic signed [ACC_WIDTH-1:0] acc_i, acc_q;
  logic signed [ACC_WIDTH-1:0] in_i_ext, in_q_ext;
  logic signed [ACC_WIDTH-1:0] sum_i, sum_q;
  logic signed [IN_WIDTH-1:0]  avg_i, avg_q;
  logic [MAX_LOG2-1:0]         cnt, cnt_last;
  logic [3:0]                  k_act, k_lim, k_eff;
  logic                        accept, dump;

  // The first sample of a block sees the freshly clamped exponent; later samples use the latched one.
  always_comb begin
    k_lim    = (decim_log2 > 4'(MAX_LOG2)) ? 4'(MAX_LOG2) : decim_log2;
    k_eff    = (cnt == '0) ? k_lim : k_act;
    cnt_last = MAX_LOG2'((MAX_LOG2 + 1)'(1) << k_eff) - MAX_LOG2'(1);
    accept   = enable & in_valid & ~clear;
    dump     = accept & (cnt == cnt_last);
    in_i_ext = {{MAX_LOG2{in_i[IN_WIDTH-1]}}, in_i};
    in_q_ext = {{MAX_LOG2{in_q[IN_WIDTH-1]}}, in_q};
    sum_i    = acc_i + in_i_ext;
    sum_q    = acc_q + in_q_ext;
    avg_i    = IN_WIDTH'(sum_i >>> k_eff);
    avg_q    = IN_WIDTH'(sum_q >>> k_eff);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_i     <= '0;
      acc_q     <= '0;
      cnt       <= '0;
      k_act     <= '0;
      out_i     <= '0;
      out_q     <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (!enable || clear) begin
        acc_i <= '0;
        acc_q <= '0;
        cnt   <= '0;
        busy  <= 1'b0;
      end else if (accept) begin
        if (cnt == '0) k_act <= k_lim;
        if (dump) begin
          out_i     <= avg_i;
          out_q     <= avg_q;
          out_valid <= 1'b1;
          acc_i     <= '0;
          acc_q     <= '0;
          cnt       <= '0;
          busy      <= 1'b0;
        end else begin
          acc_i <= sum_i;
          acc_q <= sum_q;
          cnt   <= cnt + MAX_LOG2'(1);
          busy  <= 1'b1;
        end
      end
    end
  end

endmodule
